// File: rtl/id_ex_operand_reg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_reg
//
// ID->EX pipeline register. It carries the operand bundle (pc, rs1, rs2, imm,
// alu_src, register indices) from the ID stage to the EX-stage operand muxes.
// It uses a valid/ready handshake on both sides, a synchronous flush, and has
// one cycle of latency.
//
// Configuration macro: ID_EX_FORWARD_EN
//   defined   : rs1/rs2 are resolved against the MEM and WB results, both on
//               capture and while a bundle is held by an EX stall. MEM wins
//               over WB. Register 0 never forwards.
//   undefined : rs1/rs2 capture the regfile data verbatim and then hold. The
//               mem_fwd_* and wb_fwd_* inputs are ignored.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   id_valid / id_ready      upstream handshake (id_ready is combinational)
//   id_pc .. id_alu_src      incoming bundle fields
//   flush                    kill the held and the incoming bundle
//   ex_ready / ex_valid      downstream handshake
//   ex_pc .. ex_rs2_addr     registered bundle fields
//   mem_fwd_*, wb_fwd_*      MEM / WB write-back results used for forwarding
//
// alu_src encoding: [0] data1 = pc; [2:1] data2: 00 = rs2, 01 = imm, 1x = 4.
// This block only stores alu_src. It never interprets it.
// -----------------------------------------------------------------------------
module id_ex_operand_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [ADDR_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [REG_AW-1:0]     id_rs1_addr,
    input  logic [REG_AW-1:0]     id_rs2_addr,
    input  logic [REG_AW-1:0]     id_rd_addr,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [2:0]            id_alu_src,

    input  logic                  flush,

    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [ADDR_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1,
    output logic [DATA_WIDTH-1:0] ex_rs2,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [2:0]            ex_alu_src,
    output logic [REG_AW-1:0]     ex_rd_addr,
    output logic [REG_AW-1:0]     ex_rs1_addr,
    output logic [REG_AW-1:0]     ex_rs2_addr,

    input  logic                  mem_fwd_we,
    input  logic [REG_AW-1:0]     mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic                  wb_fwd_we,
    input  logic [REG_AW-1:0]     wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data
);

    logic                  accept;    // handshake completes on the ID side
    logic                  capture;   // accept that is not killed by flush
    logic [DATA_WIDTH-1:0] rs1_next;
    logic [DATA_WIDTH-1:0] rs2_next;

    // The register can take a new bundle when it is empty or when EX is
    // draining the current one. id_valid is deliberately not involved.
    assign id_ready = !ex_valid || ex_ready;
    assign accept   = id_valid && id_ready;
    assign capture  = accept && !flush;

`ifdef ID_EX_FORWARD_EN
    logic                  hold;
    logic [REG_AW-1:0]     rs1_src;
    logic [REG_AW-1:0]     rs2_src;
    logic [DATA_WIDTH-1:0] rs1_base;
    logic [DATA_WIDTH-1:0] rs2_base;

    assign hold = ex_valid && !ex_ready;

    // The MEM result is younger than the WB result, so MEM wins when both
    // match. x0 is hard-wired to zero and must never be overridden.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_AW-1:0]     src,
        input logic [DATA_WIDTH-1:0] base,
        input logic                  m_we,
        input logic [REG_AW-1:0]     m_rd,
        input logic [DATA_WIDTH-1:0] m_data,
        input logic                  w_we,
        input logic [REG_AW-1:0]     w_rd,
        input logic [DATA_WIDTH-1:0] w_data
    );
        logic [DATA_WIDTH-1:0] res;
        res = base;
        if (src != '0) begin
            if (m_we && m_rd == src)      res = m_data;
            else if (w_we && w_rd == src) res = w_data;
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a value on every path first,
        // otherwise synthesis infers a latch.
        rs1_src  = ex_rs1_addr;
        rs2_src  = ex_rs2_addr;
        rs1_base = ex_rs1;
        rs2_base = ex_rs2;
        // On capture the operand comes from the incoming bundle. Otherwise
        // the held value is refreshed in place.
        if (accept) begin
            rs1_src  = id_rs1_addr;
            rs2_src  = id_rs2_addr;
            rs1_base = id_rs1_data;
            rs2_base = id_rs2_data;
        end
        rs1_next = fwd_sel(rs1_src, rs1_base, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);
        rs2_next = fwd_sel(rs2_src, rs2_base, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    end
`else
    // Hazards are resolved upstream by stalling. The forwarding ports exist
    // only to keep the interface identical across builds.
    logic unused_fwd;
    assign unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data};

    assign rs1_next = id_rs1_data;
    assign rs2_next = id_rs2_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm      <= '0;
            ex_alu_src  <= '0;
            ex_rd_addr  <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
        end else begin
            // Flush has priority over accept. Otherwise a consumed bundle with
            // nothing behind it empties the register.
            if (flush)         ex_valid <= 1'b0;
            else if (accept)   ex_valid <= 1'b1;
            else if (ex_ready) ex_valid <= 1'b0;

            if (capture) begin
                ex_pc       <= id_pc;
                ex_rs1      <= rs1_next;
                ex_rs2      <= rs2_next;
                ex_imm      <= id_imm;
                ex_alu_src  <= id_alu_src;
                ex_rd_addr  <= id_rd_addr;
                ex_rs1_addr <= id_rs1_addr;
                ex_rs2_addr <= id_rs2_addr;
            end
`ifdef ID_EX_FORWARD_EN
            else if (hold) begin
                // A stalled bundle keeps tracking results that retire while
                // it waits, so EX never sees a stale operand.
                ex_rs1 <= rs1_next;
                ex_rs2 <= rs2_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_reg
//
// Directed bench for id_ex_operand_reg. A bundle-level reference model tracks
// what EX must see. A negedge process compares every output against the model.
// The stimulus sequence also carries hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [2:0]    id_alu_src;
    logic          flush;
    logic          ex_ready;
    logic          ex_valid;
    logic [AW-1:0] ex_pc;
    logic [DW-1:0] ex_rs1, ex_rs2, ex_imm;
    logic [2:0]    ex_alu_src;
    logic [RW-1:0] ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic          mem_fwd_we, wb_fwd_we;
    logic [RW-1:0] mem_fwd_rd, wb_fwd_rd;
    logic [DW-1:0] mem_fwd_data, wb_fwd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_operand_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_AW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_alu_src(id_alu_src),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_alu_src(ex_alu_src), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          valid;
        logic          known;   // data fields are defined (not killed by flush)
        logic [AW-1:0] pc;
        logic [DW-1:0] rs1, rs2, imm;
        logic [2:0]    alu;
        logic [RW-1:0] rd, a1, a2;
    } bundle_t;

    bundle_t m;

    // Value an operand must take: the newest in-flight write to that register,
    // else the given fallback. x0 is never written.
    function automatic logic [DW-1:0] operand(input logic [RW-1:0] r, input logic [DW-1:0] dflt);
`ifdef ID_EX_FORWARD_EN
        if (r == 0) return dflt;
        if (mem_fwd_we && mem_fwd_rd == r) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_rd == r) return wb_fwd_data;
`endif
        return dflt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '{valid: 1'b0, known: 1'b1, pc: '0, rs1: '0, rs2: '0, imm: '0,
                  alu: '0, rd: '0, a1: '0, a2: '0};
        end else begin
            logic room;
            room = !m.valid || ex_ready;
            if (flush) begin
                m.valid = 1'b0;
                m.known = 1'b0;
            end else if (id_valid && room) begin
                m = '{valid: 1'b1, known: 1'b1, pc: id_pc,
                      rs1: operand(id_rs1_addr, id_rs1_data),
                      rs2: operand(id_rs2_addr, id_rs2_data),
                      imm: id_imm, alu: id_alu_src, rd: id_rd_addr,
                      a1: id_rs1_addr, a2: id_rs2_addr};
            end else if (m.valid && ex_ready) begin
                m.valid = 1'b0;
            end else if (m.valid) begin
                m.rs1 = operand(m.a1, m.rs1);
                m.rs2 = operand(m.a2, m.rs2);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_id_ready", id_ready, !m.valid || ex_ready);
            check("cmp_ex_valid", ex_valid, m.valid);
            if (m.known) begin
                check("cmp_pc",  ex_pc,  m.pc);
                check("cmp_rs1", ex_rs1, m.rs1);
                check("cmp_rs2", ex_rs2, m.rs2);
                check("cmp_imm", ex_imm, m.imm);
                check("cmp_alu", ex_alu_src, m.alu);
                check("cmp_rd",  ex_rd_addr, m.rd);
                check("cmp_a1",  ex_rs1_addr, m.a1);
                check("cmp_a2",  ex_rs2_addr, m.a2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [AW-1:0] pc, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                              input logic [RW-1:0] a1, input logic [RW-1:0] a2, input logic [RW-1:0] rd,
                              input logic [DW-1:0] imm, input logic [2:0] alu);
        id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_imm = imm; id_alu_src = alu;
    endtask

    logic [DW-1:0] exp_fwd;

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_bundle('0, '0, '0, '0, '0, '0, '0, '0);
        mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_we = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_valid", ex_valid, 0);
        check("reset_ready", id_ready, 1);
        check("reset_pc", ex_pc, 0);

        // Accept path
        set_bundle(32'h100, 32'd5, 32'd9, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFF0, 3'b010);
        id_valid = 1'b1;
        step();
        check("acc_valid", ex_valid, 1);
        check("acc_pc", ex_pc, 32'h100);
        check("acc_rs1", ex_rs1, 32'd5);
        check("acc_imm", ex_imm, 32'hFFFF_FFF0);
        check("acc_alu", ex_alu_src, 3'b010);

        // Back-to-back streaming, one bundle per cycle
        for (int i = 0; i < 4; i++) begin
            set_bundle(32'h200 + 32'(4 * i), 32'(i + 10), 32'(i + 20), 5'd1, 5'd2, 5'(i + 3),
                       32'(i), 3'(i));
            step();
            check("stream_pc", ex_pc, 32'h200 + 32'(4 * i));
            check("stream_rs2", ex_rs2, 32'(i + 20));
        end

        // Stall with a pending bundle
        ex_ready = 1'b0;
        set_bundle(32'h300, 32'h31, 32'h32, 5'd9, 5'd10, 5'd11, 32'h33, 3'b001);
        #1;
        check("stall_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", ex_pc, 32'h20C);
            check("stall_valid", ex_valid, 1);
        end
        ex_ready = 1'b1;
        step();
        check("land_pc", ex_pc, 32'h300);

        // Drain: data holds
        id_valid = 1'b0;
        step();
        check("drain_valid", ex_valid, 0);
        check("drain_pc", ex_pc, 32'h300);

        // Flush beats a same-cycle accept
        set_bundle(32'h400, 1, 2, 5'd1, 5'd2, 5'd3, 4, 3'b100);
        id_valid = 1'b1; flush = 1'b1;
        step();
        check("flush_valid", ex_valid, 0);
        flush = 1'b0; id_valid = 1'b0;
        step();
        check("flush_stays", ex_valid, 0);

        // Forwarding on capture: MEM over WB
        set_bundle(32'h500, 32'h11, 32'h12, 5'd3, 5'd0, 5'd5, 0, 3'b000);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAA;
        wb_fwd_we = 1'b1;  wb_fwd_rd = 5'd3;  wb_fwd_data = 32'hBB;
        id_valid = 1'b1;
        step();
`ifdef ID_EX_FORWARD_EN
        exp_fwd = 32'hAA;
`else
        exp_fwd = 32'h11;
`endif
        check("fwd_mem_prio", ex_rs1, exp_fwd);

        // x0 never forwards
        set_bundle(32'h504, 32'h22, 32'h23, 5'd0, 5'd0, 5'd5, 0, 3'b000);
        mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        step();
        check("fwd_x0", ex_rs1, 32'h22);

        // WB-only match on rs2
        set_bundle(32'h508, 32'h24, 32'h25, 5'd1, 5'd6, 5'd5, 0, 3'b000);
        mem_fwd_rd = 5'd5; wb_fwd_rd = 5'd6; wb_fwd_data = 32'hCC;
        step();
`ifdef ID_EX_FORWARD_EN
        exp_fwd = 32'hCC;
`else
        exp_fwd = 32'h25;
`endif
        check("fwd_wb", ex_rs2, exp_fwd);

        // Held refresh while EX stalls
        mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
        set_bundle(32'h600, 32'h54, 32'h55, 5'd8, 5'd7, 5'd9, 0, 3'b000);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h1234;
        step();
`ifdef ID_EX_FORWARD_EN
        exp_fwd = 32'h1234;
`else
        exp_fwd = 32'h55;
`endif
        check("hold_refresh", ex_rs2, exp_fwd);
        check("hold_pc", ex_pc, 32'h600);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h9999;
        wb_fwd_data = 32'h1111;
        step();
`ifdef ID_EX_FORWARD_EN
        exp_fwd = 32'h9999;
`else
        exp_fwd = 32'h55;
`endif
        check("hold_mem_prio", ex_rs2, exp_fwd);
        mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
        step();
        check("hold_keep", ex_rs2, exp_fwd);

        // Asynchronous reset mid-operation discards the held bundle
        rst = 1'b1;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_ready", id_ready, 1);
        check("arst_pc", ex_pc, 0);
        check("arst_rs2", ex_rs2, 0);
        step();
        rst = 1'b0; ex_ready = 1'b1;
        step();
        check("post_rst_valid", ex_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
